sync_size_down_fifo: RTL

Single-clock, parametrised width-down-converting FIFO: accepts wide words of RATIO×DATA_WIDTH bits and delivers them as RATIO narrow words of DATA_WIDTH bits in a configurable lane order. Storage is distributed RAM with asynchronous read, so the head narrow word is presented show-ahead. It is the single-clock successor of the distributed size-down FIFO. It adds a programmable down-conversion ratio, lane ordering, narrow-word read water level, and overflow/underflow error pulses. It sits between wide datapath producers and narrow stream consumers inside one clock domain.

---
 rtl/sync_size_down_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/sync_size_down_fifo.sv
// Single-clock width-down FIFO: wide words in, RATIO narrow words out in a selectable
// lane order, show-ahead from asynchronously read distributed RAM.
module sync_size_down_fifo #(
   parameter int ADDR_WIDTH       = 4,
   parameter int DATA_WIDTH       = 8,
   parameter int RATIO            = 4,
   parameter     LANE_ORDER       = "LSB_FIRST",
   parameter int ALMOST_FULL_NUM  = 4,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic [RATIO*DATA_WIDTH-1:0]            i_wr_data,
   input  logic                                   i_wr_en,
   output logic                                   o_full,
   output logic                                   o_almost_full,
   output logic [ADDR_WIDTH:0]                    o_wr_water_level,
   output logic                                   o_wr_err,
   output logic [DATA_WIDTH-1:0]                  o_rd_data,
   input  logic                                   i_rd_en,
   output logic                                   o_empty,
   output logic                                   o_almost_empty,
   output logic [ADDR_WIDTH+$clog2(RATIO):0]      o_rd_water_level,
   output logic                                   o_rd_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LOG2R = $clog2(RATIO);
   localparam int LW    = (LOG2R > 0) ? LOG2R : 1;
   localparam int RWL   = ADDR_WIDTH + LOG2R + 1;
   localparam int WW    = RATIO * DATA_WIDTH;
   localparam bit MSB_FIRST = (LANE_ORDER == "MSB_FIRST");

   localparam logic [LW-1:0]       LAST_LANE = LW'(RATIO - 1);
   localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_THR    = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_NUM);
   localparam logic [RWL-1:0]      AE_THR    = RWL'(ALMOST_EMPTY_NUM);

   logic [WW-1:0]         r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_wcnt;
   logic [LW-1:0]         r_lane;
   logic                  r_wr_err;
   logic                  r_rd_err;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_rd_free;
   logic [LW-1:0]         w_sel;
   logic [WW-1:0]         w_head;
   logic [DATA_WIDTH-1:0] w_head_lanes [RATIO];
   logic [RWL-1:0]        w_rd_level;

   assign w_full    = (r_wcnt == FULL_CNT);
   assign w_empty   = (r_wcnt == '0);
   assign w_wr_acc  = i_wr_en & ~w_full;
   assign w_rd_acc  = i_rd_en & ~w_empty;
   assign w_rd_free = w_rd_acc & (r_lane == LAST_LANE);

   // With RATIO=1 LAST_LANE is 0, so every read frees a slot and the lane stays 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wcnt   <= '0;
         r_lane   <= '0;
         r_wr_err <= 1'b0;
         r_rd_err <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) begin
            if (r_lane == LAST_LANE) begin
               r_lane   <= '0;
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
               r_lane   <= r_lane + 1'b1;
            end
         end
         case ({w_wr_acc, w_rd_free})
            2'b10:   r_wcnt <= r_wcnt + 1'b1;
            2'b01:   r_wcnt <= r_wcnt - 1'b1;
            default: r_wcnt <= r_wcnt;
         endcase
         r_wr_err <= i_wr_en & w_full;
         r_rd_err <= i_rd_en & w_empty;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign w_head = r_mem[r_rd_ptr];
   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign w_head_lanes[g] = w_head[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_sel      = MSB_FIRST ? (LAST_LANE - r_lane) : r_lane;
   assign w_rd_level = (RWL'(r_wcnt) << LOG2R) - RWL'(r_lane);

   assign o_rd_data        = w_head_lanes[w_sel];
   assign o_full           = w_full;
   assign o_empty          = w_empty;
   assign o_almost_full    = (r_wcnt >= AF_THR);
   assign o_almost_empty   = (w_rd_level <= AE_THR);
   assign o_wr_water_level = r_wcnt;
   assign o_rd_water_level = w_rd_level;
   assign o_wr_err         = r_wr_err;
   assign o_rd_err         = r_rd_err;

endmodule
